mips_multicycle_core: RTL and testbench
=======================================

MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

Interface
REQ-001 Parameter DATA_W, default 8: register/datapath width; legal values 8..32.
REQ-002 Parameter IMEM_AW, default 3: instruction memory address width; depth is 2**IMEM_AW words of 32 bits.
REQ-003 Parameter OUTPUT_REG, default 5: register index driven onto result_data at program end.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  run request; sampled in IDLE and DONE only.
REQ-007 prog_len  in  IMEM_AW+1  instruction count to execute; sampled with start.
REQ-008 imem_we  in  1  instruction-memory write strobe.
REQ-009 imem_waddr  in  IMEM_AW  instruction-memory write address.
REQ-010 imem_wdata  in  32  instruction word to write.
REQ-011 busy  out  1  high from FETCH through WB.
REQ-012 done  out  1  program complete; result_data valid.
REQ-013 result_data  out  DATA_W  value of register OUTPUT_REG at completion.
REQ-014 err  out  1  sticky invalid-instruction flag (see REQ-031).

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, DECODE, READ, EXEC, WB, DONE; each instruction SHALL take exactly 5 cycles (FETCH..WB).
REQ-016 IDLE/DONE with start=1: latch prog_len (clamped to 2**IMEM_AW), PC<=0, done<=0, err<=0, go to FETCH; if prog_len==0, go to DONE instead.
REQ-017 FETCH: IR<=imem[PC], PC<=PC+1. DECODE: opcode=IR[31:26], rs=IR[25:21]; R-type (opcode 0): rt=IR[20:16], rd=IR[15:11], funct=IR[5:0]; I-type: dest=IR[20:16], imm=IR[15:0].
REQ-018 READ: latch rs and rt operands from the register file.
REQ-019 EXEC, R-type funct: 0x21 addu, 0x23 subu, 0x24 and, 0x25 or, 0x2A slt (signed compare, result 1/0); shamt ignored.
REQ-020 EXEC, I-type opcode: 0x09 addiu (imm sign-extended), 0x0C andi, 0x0D ori (imm zero-extended); imm SHALL be extended to 32 bits then truncated to DATA_W.
REQ-021 All arithmetic SHALL be modulo 2**DATA_W; no overflow detection.
REQ-022 Any other opcode/funct SHALL be invalid: no register write.
REQ-023 WB: write result to dest unless invalid or dest==0; register 0 SHALL always read 0. Then FETCH if executed count < latched prog_len, else DONE.
REQ-024 DONE: on the first DONE cycle result_data<=reg[OUTPUT_REG] and done<=1; both held until the next start.
REQ-025 The register file SHALL persist across runs; only rst_n clears it.
REQ-026 imem writes SHALL take effect only when busy=0; writes while busy SHALL be ignored.
REQ-027 start while busy SHALL be ignored.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, PC=0, busy=0, done=0, err=0, result_data=0, all 32 registers=0, regardless of state; instruction memory contents SHALL be preserved.
REQ-029 On rst_n release the core SHALL wait in IDLE for start.

Configuration
REQ-030 Macro INVALID_TRAP_EN selects invalid-instruction handling.
REQ-031 With INVALID_TRAP_EN defined: an invalid instruction in EXEC SHALL set err=1 and the WB of that instruction SHALL go to DONE (remaining instructions not executed).
REQ-032 Without INVALID_TRAP_EN: invalid instructions SHALL execute as NOPs, err SHALL be tied 0.

Verification
REQ-033 Load addiu $1,$0,45; addiu $2,$0,-20; addiu $3,$0,-60; addiu $4,$0,30; addu $5,$1,$2; addu $6,$3,$4; subu $5,$5,$6; start with prog_len=7 at edge k -> done rises at edge k+37, result_data=0x37, busy low.
REQ-034 DATA_W=16, program addiu $5,$0,-1; ori $5,$5,0x00F0 -> result_data=0xFFFF; andi variant with 0x00F0 -> 0x00F0.
REQ-035 slt $5,$1,$2 with $1=-3,$2=2 -> result_data=1; swapped operands -> 0; addiu $0,$0,7 leaves $0=0.
REQ-036 Invalid funct 0x3F as instruction 2 of 3: with INVALID_TRAP_EN -> err=1, done after 2 instructions (edge k+12); without -> err=0, all 3 executed.
REQ-037 Assert rst_n low during EXEC of instruction 4 -> busy/done/result_data 0 same cycle; restart with prog_len=7 -> same 0x37 result.
REQ-038 imem write during busy and start during busy -> no effect on program or result; prog_len=0 -> done with result_data=reg[5] unchanged.

Source files
------------

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core
//   Five-cycle-per-instruction MIPS subset core (FETCH, DECODE, READ, EXEC, WB)
//   with a small writable instruction memory and a 32-entry register file.
//   Supported: addu, subu, and, or, slt, addiu, andi, ori.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i         run request, sampled in IDLE and DONE only
//   prog_len_i      instruction count to execute, sampled with start_i
//   imem_we_i       instruction-memory write strobe, ignored while busy
//   imem_waddr_i    instruction-memory write address
//   imem_wdata_i    instruction word
//   busy_o          high while an instruction is in flight (FETCH..WB)
//   done_o          program complete, result_data_o valid
//   result_data_o   register OUTPUT_REG captured on completion
//   err_o           sticky invalid-instruction flag
//
// Configuration
//   INVALID_TRAP_EN  defined: an invalid instruction sets err_o and ends the run
//                    after its WB. Undefined: invalid instructions are NOPs and
//                    err_o is tied low.
module mips_multicycle_core #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned IMEM_AW    = 3,
  parameter int unsigned OUTPUT_REG = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [IMEM_AW:0]   prog_len_i,
  input  logic               imem_we_i,
  input  logic [IMEM_AW-1:0] imem_waddr_i,
  input  logic [31:0]        imem_wdata_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [DATA_W-1:0]  result_data_o,
  output logic               err_o
);

  localparam int unsigned     PC_W    = IMEM_AW + 1;
  localparam int unsigned     DEPTH   = 1 << IMEM_AW;
  localparam logic [4:0]      OUT_IDX = 5'(OUTPUT_REG);
  localparam logic [PC_W-1:0] MAX_LEN = PC_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_READ   = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   len_q;
  logic [31:0]       ir_q;
  logic [DATA_W-1:0] a_q, b_q, alu_q;
  logic              inv_q;
  logic [4:0]        dest_q;
  logic              busy_q, done_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] rf_q [32];
  logic [31:0]       imem_q [DEPTH];

  logic [5:0]        opcode_c, funct_c;
  logic [4:0]        rs_c, rt_c, rd_c, dest_c;
  logic [15:0]       imm_c;
  logic [DATA_W-1:0] alu_c;
  logic              inv_c;
  logic              trap_c;

  assign opcode_c = ir_q[31:26];
  assign rs_c     = ir_q[25:21];
  assign rt_c     = ir_q[20:16];
  assign rd_c     = ir_q[15:11];
  assign funct_c  = ir_q[5:0];
  assign imm_c    = ir_q[15:0];

  // ALU and instruction validity; immediates are extended to 32 bits before truncation
  always_comb begin
    alu_c  = '0;
    inv_c  = 1'b0;
    dest_c = rt_c;
    if (opcode_c == 6'h00) begin
      dest_c = rd_c;
      case (funct_c)
        6'h21:   alu_c = a_q + b_q;
        6'h23:   alu_c = a_q - b_q;
        6'h24:   alu_c = a_q & b_q;
        6'h25:   alu_c = a_q | b_q;
        6'h2A:   alu_c = ($signed(a_q) < $signed(b_q)) ? DATA_W'(1) : '0;
        default: inv_c = 1'b1;
      endcase
    end else begin
      case (opcode_c)
        6'h09:   alu_c = a_q + DATA_W'({{16{imm_c[15]}}, imm_c});
        6'h0C:   alu_c = a_q & DATA_W'({16'h0000, imm_c});
        6'h0D:   alu_c = a_q | DATA_W'({16'h0000, imm_c});
        default: inv_c = 1'b1;
      endcase
    end
  end

`ifdef INVALID_TRAP_EN
  logic err_q;

  assign trap_c = inv_q;
  assign err_o  = err_q;

  // Sticky error, cleared only by reset or an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((state_q == S_IDLE || state_q == S_DONE) && start_i) begin
      err_q <= 1'b0;
    end else if (state_q == S_EXEC && inv_c) begin
      err_q <= 1'b1;
    end
  end
`else
  assign trap_c = 1'b0;
  assign err_o  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; pc_q equals the executed count once in WB
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) state_d = (prog_len_i == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_READ;
      S_READ:   state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB: begin
        if (trap_c)             state_d = S_DONE;
        else if (pc_q < len_q)  state_d = S_FETCH;
        else                    state_d = S_DONE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath, register file and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      len_q    <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      alu_q    <= '0;
      inv_q    <= 1'b0;
      dest_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      busy_q <= (state_d != S_IDLE) && (state_d != S_DONE);
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            len_q  <= (prog_len_i > MAX_LEN) ? MAX_LEN : prog_len_i;
            pc_q   <= '0;
            done_q <= 1'b0;
          end else if (state_q == S_DONE && !done_q) begin
            done_q   <= 1'b1;
            result_q <= rf_q[OUT_IDX];
          end
        end
        S_FETCH: begin
          ir_q <= imem_q[pc_q[IMEM_AW-1:0]];
          pc_q <= pc_q + PC_W'(1);
        end
        S_READ: begin
          a_q <= rf_q[rs_c];
          b_q <= rf_q[rt_c];
        end
        S_EXEC: begin
          alu_q  <= alu_c;
          inv_q  <= inv_c;
          dest_q <= dest_c;
        end
        S_WB: begin
          // Register 0 is never written so it always reads zero
          if (!inv_q && dest_q != 5'd0) rf_q[dest_q] <= alu_q;
        end
        default: ;
      endcase
    end
  end

  // Instruction memory: not reset, writable only while idle
  always_ff @(posedge clk) begin
    if (imem_we_i && !busy_q) imem_q[imem_waddr_i] <= imem_wdata_i;
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign result_data_o = result_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
module tb_mips_multicycle_core;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;
  localparam longint unsigned MASK = (64'd1 << DW) - 64'd1;
`ifdef INVALID_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [AW:0]   prog_len_i = '0;
  logic          imem_we_i = 1'b0;
  logic [AW-1:0] imem_waddr_i = '0;
  logic [31:0]   imem_wdata_i = '0;
  logic          busy_o, done_o, err_o;
  logic [DW-1:0] result_data_o;

  mips_multicycle_core #(.DATA_W(DW), .IMEM_AW(AW), .OUTPUT_REG(5)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .prog_len_i(prog_len_i),
    .imem_we_i(imem_we_i), .imem_waddr_i(imem_waddr_i), .imem_wdata_i(imem_wdata_i),
    .busy_o(busy_o), .done_o(done_o), .result_data_o(result_data_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0]     mimem [DEPTH];
  longint unsigned mrf [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(int f, int rs, int rt, int rd);
    logic [31:0] w;
    w = '0;
    w[25:21] = 5'(rs);
    w[20:16] = 5'(rt);
    w[15:11] = 5'(rd);
    w[5:0]   = 6'(f);
    return w;
  endfunction

  function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
    logic [31:0] w;
    w = '0;
    w[31:26] = 6'(op);
    w[25:21] = 5'(rs);
    w[20:16] = 5'(rt);
    w[15:0]  = 16'(imm);
    return w;
  endfunction

  function automatic longint sx(longint unsigned v);
    longint s;
    s = longint'(v << (64 - DW));
    return s >>> (64 - DW);
  endfunction

  // Architectural model: runs the program on the bench copy of imem/registers
  task automatic model_run(input int len, output int n_exec, output logic [31:0] res,
                           output logic err);
    int n;
    n = (len > int'(DEPTH)) ? int'(DEPTH) : len;
    n_exec = 0;
    err = 1'b0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      logic [5:0] op, fn;
      int rs, rt, rd, dest;
      longint unsigned a, b, v, zimm;
      longint simm;
      bit ok;
      w = mimem[i];
      op = w[31:26];
      fn = w[5:0];
      rs = int'(w[25:21]);
      rt = int'(w[20:16]);
      rd = int'(w[15:11]);
      a = mrf[rs];
      b = mrf[rt];
      zimm = longint'(w[15:0]);
      simm = longint'($signed(w[15:0]));
      ok = 1'b1;
      v = 0;
      if (op == 6'h00) begin
        dest = rd;
        case (fn)
          6'h21: v = a + b;
          6'h23: v = a - b;
          6'h24: v = a & b;
          6'h25: v = a | b;
          6'h2A: v = (sx(a) < sx(b)) ? 64'd1 : 64'd0;
          default: ok = 1'b0;
        endcase
      end else begin
        dest = rt;
        case (op)
          6'h09: v = a + longint'(simm);
          6'h0C: v = a & zimm;
          6'h0D: v = a | zimm;
          default: ok = 1'b0;
        endcase
      end
      n_exec++;
      if (!ok) begin
        if (TRAP) begin
          err = 1'b1;
          break;
        end
      end else if (dest != 0) begin
        mrf[dest] = v & MASK;
      end
    end
    res = 32'(mrf[5]);
  endtask

  task automatic load(input logic [31:0] p[$]);
    for (int i = 0; i < int'(DEPTH); i++) begin
      mimem[i] = (i < p.size()) ? p[i] : 32'h0;
      imem_we_i = 1'b1;
      imem_waddr_i = AW'(i);
      imem_wdata_i = mimem[i];
      @(posedge clk);
      #1;
    end
    imem_we_i = 1'b0;
  endtask

  // Start a run, optionally hammer start/imem while busy, and check against the model
  task automatic run(input string tag, input int len, input bit noise);
    int n_exec, cyc, exp_cyc;
    logic [31:0] er;
    logic ee;
    model_run(len, n_exec, er, ee);
    exp_cyc = 5 * n_exec + 2;
    start_i = 1'b1;
    prog_len_i = (AW + 1)'(len);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      start_i = 1'b0;
      imem_we_i = 1'b0;
      if (cyc == 1) chk({tag, " busy1"}, 32'(busy_o), 32'(n_exec > 0));
      if (noise && cyc < 5 * n_exec) begin
        start_i = 1'($urandom % 2);
        prog_len_i = (AW + 1)'($urandom);
        imem_we_i = 1'b1;
        imem_waddr_i = AW'($urandom);
        imem_wdata_i = $urandom;
      end
    end while (!done_o && cyc < 400);
    start_i = 1'b0;
    imem_we_i = 1'b0;
    chk({tag, " cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, " result"}, 32'(result_data_o), er);
    chk({tag, " err"}, 32'(err_o), 32'(ee));
    chk({tag, " busy"}, 32'(busy_o), 32'h0);
  endtask

  function automatic logic [31:0] rand_instr();
    int k, rs, rt, rd, imm;
    k  = int'($urandom_range(0, 19));
    rs = int'($urandom_range(0, 7));
    rt = int'($urandom_range(0, 7));
    rd = int'($urandom_range(0, 7));
    imm = int'($urandom);
    if ($urandom_range(0, 2) == 0) begin
      rd = 5;
      rt = 5;
    end
    case (k)
      0, 1, 2:  return rtype('h21, rs, rt, rd);
      3, 4:     return rtype('h23, rs, rt, rd);
      5:        return rtype('h24, rs, rt, rd);
      6:        return rtype('h25, rs, rt, rd);
      7, 8:     return rtype('h2A, rs, rt, rd);
      9, 10, 11, 12: return itype('h09, rs, rt, imm);
      13, 14:   return itype('h0C, rs, rt, imm);
      15, 16:   return itype('h0D, rs, rt, imm);
      17:       return rtype('h3F, rs, rt, rd);
      default:  return itype('h3F, rs, rt, imm);
    endcase
  endfunction

  initial begin
    logic [31:0] p33[$];
    logic [31:0] p[$];

    foreach (mrf[i]) mrf[i] = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy_o), 32'h0);
    chk("reset done", 32'(done_o), 32'h0);
    chk("reset result", 32'(result_data_o), 32'h0);
    chk("reset err", 32'(err_o), 32'h0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle wait", 32'({busy_o, done_o}), 32'h0);

    // Reference program: 45 + -20 - (-60 + 30) = 55
    p33 = '{itype('h09, 0, 1, 45), itype('h09, 0, 2, -20), itype('h09, 0, 3, -60),
            itype('h09, 0, 4, 30), rtype('h21, 1, 2, 5), rtype('h21, 3, 4, 6),
            rtype('h23, 5, 6, 5)};
    load(p33);
    run("prog7", 7, 1'b0);
    chk("prog7 const", 32'(result_data_o), 32'h37);

    p = '{itype('h09, 0, 5, -1), itype('h0D, 5, 5, 'hF0)};
    load(p);
    run("ori", 2, 1'b0);
    chk("ori const", 32'(result_data_o), 32'hFFFF);
    p = '{itype('h09, 0, 5, -1), itype('h0C, 5, 5, 'hF0)};
    load(p);
    run("andi", 2, 1'b0);
    chk("andi const", 32'(result_data_o), 32'h00F0);

    p = '{itype('h09, 0, 1, -3), itype('h09, 0, 2, 2), rtype('h2A, 1, 2, 5)};
    load(p);
    run("slt", 3, 1'b0);
    chk("slt const", 32'(result_data_o), 32'h1);
    p = '{itype('h09, 0, 1, -3), itype('h09, 0, 2, 2), rtype('h2A, 2, 1, 5)};
    load(p);
    run("slt swap", 3, 1'b0);
    chk("slt swap const", 32'(result_data_o), 32'h0);
    p = '{itype('h09, 0, 5, 9), itype('h09, 0, 0, 7), rtype('h21, 0, 0, 5)};
    load(p);
    run("r0", 3, 1'b0);
    chk("r0 const", 32'(result_data_o), 32'h0);

    p = '{itype('h09, 0, 5, 1), rtype('h3F, 5, 5, 5), itype('h09, 5, 5, 2)};
    load(p);
    run("invalid", 3, 1'b0);
    chk("invalid const", 32'(result_data_o), TRAP ? 32'h1 : 32'h3);
    chk("invalid err const", 32'(err_o), TRAP ? 32'h1 : 32'h0);

    // Reset during EXEC of instruction 4
    load(p33);
    start_i = 1'b1;
    prog_len_i = 4'd7;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (18) @(posedge clk);
    #1;
    chk("midrun busy", 32'(busy_o), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun rst busy", 32'(busy_o), 32'h0);
    chk("midrun rst done", 32'(done_o), 32'h0);
    chk("midrun rst result", 32'(result_data_o), 32'h0);
    foreach (mrf[i]) mrf[i] = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run("rerun", 7, 1'b0);
    chk("rerun const", 32'(result_data_o), 32'h37);

    run("noisy", 7, 1'b1);
    chk("noisy const", 32'(result_data_o), 32'h37);
    run("len0", 0, 1'b0);
    chk("len0 const", 32'(result_data_o), 32'h37);

    for (int t = 0; t < 25; t++) begin
      p.delete();
      for (int i = 0; i < int'(DEPTH); i++) p.push_back(rand_instr());
      load(p);
      run($sformatf("rand%0d", t), int'($urandom_range(0, 12)), 1'($urandom % 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
